// File: rtl/trig_sched_pkg.sv
// Shared types and default sizes for the beam trigger scheduler.
package trig_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int DEF_NBEAMS       = 2;
    localparam int DEF_TIME_BITS    = 32;
    localparam int DEF_HOLDOFF_BITS = 16;
    localparam int DEF_DROP_BITS    = 16;

endpackage

// File: rtl/trig_sat_counter.sv
// Saturating up-counter. A clear has priority over a coincident increment.
module trig_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/trig_beam_scheduler.sv
// Masks per-beam triggers, merges coincident beams into one timestamped message,
// applies a programmable holdoff and counts triggers lost while busy.
module trig_beam_scheduler
    import trig_sched_pkg::*;
#(
    parameter int NBEAMS       = DEF_NBEAMS,
    parameter int TIME_BITS    = DEF_TIME_BITS,
    parameter int HOLDOFF_BITS = DEF_HOLDOFF_BITS,
    parameter int DROP_BITS    = DEF_DROP_BITS
) (
    input  logic                    ifclk,
    input  logic                    ifclk_rstn,
    input  logic [NBEAMS-1:0]       trig_i,
    input  logic [NBEAMS-1:0]       beam_en_i,
    input  logic                    enable_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    drop_clr_i,
    output logic                    trig_valid_o,
    input  logic                    trig_ready_i,
    output logic [NBEAMS-1:0]       trig_beams_o,
    output logic [TIME_BITS-1:0]    trig_time_o,
    output logic                    busy_o,
    output logic [DROP_BITS-1:0]    drop_count_o
);

    logic [NBEAMS-1:0]       masked;
    logic                    fire;
    logic                    drop_inc;

    state_t                  state_reg;
    logic                    valid_reg;
    logic                    busy_reg;
    logic [NBEAMS-1:0]       beams_reg;
    logic [TIME_BITS-1:0]    time_reg;
    logic [TIME_BITS-1:0]    ts_reg;
    logic [HOLDOFF_BITS-1:0] cnt_reg;

    for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_mask
        assign masked[gi] = trig_i[gi] & beam_en_i[gi];
    end

    assign fire     = (|masked) & enable_i;
    // Any qualified trigger seen while a message is outstanding or in deadtime is lost,
    // including the cycle on which the pending message is handed off.
    assign drop_inc = fire & (state_reg != IDLE);

    always_ff @(posedge ifclk or negedge ifclk_rstn) begin
        if (!ifclk_rstn) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            beams_reg <= '0;
            time_reg  <= '0;
            ts_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        beams_reg <= masked;
                        time_reg  <= ts_reg;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= PENDING;
                    end
                end
                PENDING: begin
                    // valid is held regardless of enable_i until the handshake completes
                    if (trig_ready_i) begin
                        valid_reg <= 1'b0;
                        if (holdoff_i == '0) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg   <= holdoff_i;
                            state_reg <= HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == HOLDOFF_BITS'(1)) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    trig_sat_counter #(
        .WIDTH (DROP_BITS)
    ) u_drop_cnt (
        .clk   (ifclk),
        .rst_n (ifclk_rstn),
        .inc   (drop_inc),
        .clr   (drop_clr_i),
        .count (drop_count_o)
    );

    assign trig_valid_o = valid_reg;
    assign trig_beams_o = beams_reg;
    assign trig_time_o  = time_reg;
    assign busy_o       = busy_reg;

endmodule

// File: tb/tb_trig_beam_scheduler.sv
// Directed bench for trig_beam_scheduler: expected messages queued at stimulus time,
// popped and compared when the DUT presents them.
module tb_trig_beam_scheduler;

    localparam int NB = 2;
    localparam int TB = 32;
    localparam int HB = 16;
    localparam int DB = 4;

    typedef struct packed {
        logic [NB-1:0] beams;
        logic [TB-1:0] t;
    } msg_t;

    logic          ifclk = 1'b0;
    logic          ifclk_rstn;
    logic [NB-1:0] trig_i;
    logic [NB-1:0] beam_en_i;
    logic          enable_i;
    logic [HB-1:0] holdoff_i;
    logic          drop_clr_i;
    logic          trig_valid_o;
    logic          trig_ready_i;
    logic [NB-1:0] trig_beams_o;
    logic [TB-1:0] trig_time_o;
    logic          busy_o;
    logic [DB-1:0] drop_count_o;

    msg_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [TB-1:0] tb_ts;

    trig_beam_scheduler #(
        .NBEAMS       (NB),
        .TIME_BITS    (TB),
        .HOLDOFF_BITS (HB),
        .DROP_BITS    (DB)
    ) dut (
        .ifclk        (ifclk),
        .ifclk_rstn   (ifclk_rstn),
        .trig_i       (trig_i),
        .beam_en_i    (beam_en_i),
        .enable_i     (enable_i),
        .holdoff_i    (holdoff_i),
        .drop_clr_i   (drop_clr_i),
        .trig_valid_o (trig_valid_o),
        .trig_ready_i (trig_ready_i),
        .trig_beams_o (trig_beams_o),
        .trig_time_o  (trig_time_o),
        .busy_o       (busy_o),
        .drop_count_o (drop_count_o)
    );

    always #5 ifclk = ~ifclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge ifclk);
        #1;
        tb_ts = tb_ts + 1;
    endtask

    task automatic expect_msg(input string tag, input int max_wait);
        msg_t m;
        for (int i = 0; i < max_wait && !trig_valid_o; i++) step();
        check({tag, "_valid"}, trig_valid_o, 1'b1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            m = sb.pop_front();
            check({tag, "_beams"}, trig_beams_o, m.beams);
            check({tag, "_time"}, trig_time_o, m.t);
            $display("msg %s beams=%b time=%0d", tag, trig_beams_o, trig_time_o);
        end
    endtask

    task automatic clear_drops(input string tag);
        drop_clr_i = 1'b1;
        step();
        drop_clr_i = 1'b0;
        check(tag, drop_count_o, 0);
    endtask

    initial begin
        logic [TB-1:0] t3;
        ifclk_rstn   = 1'b0;
        trig_i       = '0;
        beam_en_i    = '0;
        enable_i     = 1'b0;
        holdoff_i    = '0;
        drop_clr_i   = 1'b0;
        trig_ready_i = 1'b0;
        tb_ts        = '0;
        repeat (3) @(posedge ifclk);
        #1;
        check("rst_valid", trig_valid_o, 0);
        check("rst_beams", trig_beams_o, 0);
        check("rst_time", trig_time_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_drop", drop_count_o, 0);
        ifclk_rstn   = 1'b1;
        tb_ts        = '0;
        beam_en_i    = 2'b11;
        enable_i     = 1'b1;
        trig_ready_i = 1'b1;

        // 1) single trigger captured at timestamp 100, one-cycle valid
        while (tb_ts != 100) step();
        trig_i = 2'b10;
        sb.push_back('{beams: 2'b10, t: tb_ts});
        step();
        trig_i = 2'b00;
        expect_msg("t1", 0);
        step();
        check("t1_valid_low", trig_valid_o, 0);
        check("t1_busy_low", busy_o, 0);

        // 2) holdoff 5 with trigger held 10 cycles: captures at cycles 0 and 7;
        //    drops on cycles 1..6 and 8..9 (handshakes plus holdoff cycles) = 8
        clear_drops("t2_clr");
        holdoff_i = 16'd5;
        trig_i    = 2'b01;
        sb.push_back('{beams: 2'b01, t: tb_ts});
        sb.push_back('{beams: 2'b01, t: tb_ts + 7});
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0 || i == 7) expect_msg("t2", 0);
            else check("t2_valid_low", trig_valid_o, 0);
            if (i == 1) check("t2_busy_holdoff", busy_o, 1);
            if (i == 6) check("t2_busy_idle", busy_o, 0);
        end
        trig_i = 2'b00;
        check("t2_drops", drop_count_o, 8);
        repeat (6) step();
        check("t2_idle", busy_o, 0);
        holdoff_i = '0;

        // 3) stalled downstream, enable dropped mid-wait
        clear_drops("t3_clr");
        trig_ready_i = 1'b0;
        trig_i       = 2'b01;
        t3           = tb_ts;
        sb.push_back('{beams: 2'b01, t: t3});
        step();
        expect_msg("t3", 0);
        for (int i = 0; i < 20; i++) begin
            if (i == 8) enable_i = 1'b0;
            step();
            check("t3_hold_valid", trig_valid_o, 1);
            check("t3_hold_beams", trig_beams_o, 2'b01);
            check("t3_hold_time", trig_time_o, t3);
        end
        trig_ready_i = 1'b1;
        step();
        check("t3_accept", trig_valid_o, 0);
        check("t3_drops", drop_count_o, 8);
        step();
        check("t3_no_capture_disabled", trig_valid_o, 0);
        trig_i   = 2'b00;
        enable_i = 1'b1;

        // 4) beam mask
        clear_drops("t4_clr");
        beam_en_i = 2'b01;
        trig_i    = 2'b10;
        repeat (3) step();
        check("t4_masked_valid", trig_valid_o, 0);
        check("t4_masked_drop", drop_count_o, 0);
        trig_i = 2'b11;
        sb.push_back('{beams: 2'b01, t: tb_ts});
        step();
        trig_i = 2'b00;
        expect_msg("t4", 0);
        step();
        check("t4_valid_low", trig_valid_o, 0);
        beam_en_i = 2'b11;

        // 5) 20 drops saturate a 4-bit counter; clear beats a coincident drop
        clear_drops("t5_clr");
        trig_ready_i = 1'b0;
        trig_i       = 2'b01;
        sb.push_back('{beams: 2'b01, t: tb_ts});
        step();
        expect_msg("t5", 0);
        repeat (20) step();
        check("t5_saturate", drop_count_o, 15);
        drop_clr_i = 1'b1;
        step();
        drop_clr_i = 1'b0;
        check("t5_clr_wins", drop_count_o, 0);
        step();
        check("t5_count_resumes", drop_count_o, 1);
        check("t5_still_valid", trig_valid_o, 1);

        // 6) async reset while PENDING; timestamp restarts at 0
        #2;
        ifclk_rstn = 1'b0;
        #1;
        check("t6_rst_valid", trig_valid_o, 0);
        check("t6_rst_beams", trig_beams_o, 0);
        check("t6_rst_time", trig_time_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_drop", drop_count_o, 0);
        trig_i       = 2'b10;
        trig_ready_i = 1'b1;
        @(posedge ifclk);
        #1;
        ifclk_rstn = 1'b1;
        tb_ts      = '0;
        check("t6_idle_after", trig_valid_o, 0);
        sb.push_back('{beams: 2'b10, t: tb_ts});
        step();
        trig_i = 2'b00;
        expect_msg("t6", 0);
        step();
        check("t6_valid_low", trig_valid_o, 0);
        check("t6_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
